// File: rtl/uart_rx_frame.sv
// +--------------------------------------------------------------------------+
// | uart_rx_frame: 16x-oversampled 8N1-style UART receiver with a one-entry  |
// | output register, framing-error and sticky overrun flags.                 |
// | Option macro: UART_RX_MAJORITY_VOTE_EN (2-of-3 vote per sample point).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_frame #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rd_uart,
  output logic [DBIT-1:0] dout,
  output logic            rx_valid,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [4:0] C_START_MID = 5'd7;
  localparam logic [4:0] C_BIT_LAST  = 5'd15;
  localparam logic [4:0] C_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] C_N_LAST    = 3'(DBIT - 1);

  logic            sync1_q;
  logic            rxs_q;
  state_t          state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q;
  logic            rx_valid_q;
  logic            frame_err_q;
  logic            overrun_q;
  logic            sample;
  logic            done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // History of rxs at the two previous ticks; every target tick is preceded by
  // two ticks in the same state, so a free-running shift lines up with s.
  logic [1:0] vote_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vote_q <= 2'b11;
    end else if (s_tick) begin
      vote_q <= {vote_q[0], rxs_q};
    end
  end

  assign sample = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs_q) | (vote_q[0] & rxs_q);
`else
  assign sample = rxs_q;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          s_d     = 5'd0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == C_START_MID) begin
            if (!sample) begin
              state_d = DATA;
              s_d     = 5'd0;
              n_d     = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == C_BIT_LAST) begin
            s_d = 5'd0;
            b_d = {sample, b_q[DBIT-1:1]};
            if (n_q == C_N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == C_STOP_LAST) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      s_q         <= 5'd0;
      n_q         <= 3'd0;
      b_q         <= '0;
      dout_q      <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      // A completing frame takes priority over a read in the same cycle.
      if (done) begin
        dout_q      <= b_q;
        frame_err_q <= ~sample;
        rx_valid_q  <= 1'b1;
        if (rx_valid_q && !rd_uart) begin
          overrun_q <= 1'b1;
        end
      end else if (rd_uart) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
    end
  end

  assign rx_done_tick = done & reset;
  assign dout         = dout_q;
  assign rx_valid     = rx_valid_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// +--------------------------------------------------------------------------+
// | tb_uart_rx_frame: scoreboard bench for uart_rx_frame (DBIT=8, SB_TICK=16)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_frame;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int C_FRAME = 16 + 16 * DBIT + SB_TICK;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       fe;
    logic       ov;
  } res_t;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       s_tick  = 1'b0;
  logic       rx      = 1'b1;
  logic       rd_uart = 1'b0;
  logic [7:0] dout;
  logic       rx_valid;
  logic       rx_done_tick;
  logic       frame_err;
  logic       overrun;

  res_t exp_q[$];
  res_t obs_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt    = 0;
  int   tick_div    = 0;
  bit   cap_pending = 1'b0;
  bit   exp_valid   = 1'b0;
  bit   exp_ovr     = 1'b0;

  uart_rx_frame #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .rd_uart     (rd_uart),
    .dout        (dout),
    .rx_valid    (rx_valid),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_div = (tick_div + 1) % 16;
      s_tick   = (tick_div == 0);
    end
  end

  // Word state is captured the cycle after each done pulse.
  always @(negedge clk) begin
    if (cap_pending) begin
      obs_q.push_back({dout, rx_valid, frame_err, overrun});
      cap_pending = 1'b0;
    end
    if (rx_done_tick === 1'b1) begin
      done_cnt++;
      cap_pending = 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Line level driven after tick t of a frame; t==gt forces a one-tick low glitch.
  function automatic logic lvl_of(input logic [7:0] data, input logic stop_ok, input int t,
                                  input int gt);
    if (t == gt) return 1'b0;
    if (t < 16) return 1'b0;
    if (t < 16 + 16 * DBIT) return data[(t - 16) / 16];
    if (!stop_ok && t < 16 + 16 * DBIT + 8) return 1'b0;
    return 1'b1;
  endfunction

  task automatic next_tick();
    do @(posedge clk); while (s_tick !== 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_ok, input int gt,
                            input int nt);
    for (int t = 0; t < nt; t++) begin
      next_tick();
      #1;
      rx = lvl_of(data, stop_ok, t, gt);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic fe);
    exp_ovr = exp_ovr | exp_valid;
    exp_valid = 1'b1;
    exp_q.push_back({d, 1'b1, fe, exp_ovr});
  endtask

  task automatic do_read();
    @(posedge clk);
    #1 rd_uart = 1'b1;
    @(posedge clk);
    #1 rd_uart = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 400 && obs_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({dout, rx_valid, rx_done_tick, frame_err, overrun} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state: got dout=%h valid=%b done=%b ferr=%b ovr=%b, expected all 0",
               dout, rx_valid, rx_done_tick, frame_err, overrun);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_frame_a5();
    res_t o, e;
    int   d0 = done_cnt;
    push_exp(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1, -1, C_FRAME);
    wait_obs(1);
    e = exp_q.pop_front();
    vectors++;
    if (obs_q.size() == 0) begin
      miscompares++;
      $display("FAIL a5_frame: no word captured, expected dout=%h", e.d);
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        miscompares++;
        $display("FAIL a5_frame: got dout=%h v=%b fe=%b ov=%b, expected dout=%h v=%b fe=%b ov=%b",
                 o.d, o.v, o.fe, o.ov, e.d, e.v, e.fe, e.ov);
      end
    end
    vectors++;
    if (done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL a5_done_count: got %0d pulses, expected 1", done_cnt - d0);
    end
    do_read();
    vectors++;
    if (rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL a5_read_clear: got rx_valid=%b, expected 0", rx_valid);
    end
  endtask

  task automatic test_start_glitch();
    int d0 = done_cnt;
    for (int t = 0; t < 40; t++) begin
      next_tick();
      #1;
      rx = (t < 4) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    vectors++;
    if (done_cnt !== d0) begin
      miscompares++;
      $display("FAIL start_glitch_done: got %0d pulses, expected 0", done_cnt - d0);
    end
    vectors++;
    if (rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL start_glitch_valid: got rx_valid=%b, expected 0", rx_valid);
    end
  endtask

  task automatic test_frame_err();
    res_t o, e;
    push_exp(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b0, -1, C_FRAME);
    wait_obs(1);
    e = exp_q.pop_front();
    vectors++;
    if (obs_q.size() == 0) begin
      miscompares++;
      $display("FAIL ferr_frame: no word captured, expected dout=%h", e.d);
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        miscompares++;
        $display("FAIL ferr_frame: got dout=%h v=%b fe=%b ov=%b, expected dout=%h v=%b fe=%b ov=%b",
                 o.d, o.v, o.fe, o.ov, e.d, e.v, e.fe, e.ov);
      end
    end
    do_read();
    push_exp(8'h55, 1'b0);
    send_frame(8'h55, 1'b1, -1, C_FRAME);
    wait_obs(1);
    e = exp_q.pop_front();
    vectors++;
    if (obs_q.size() == 0) begin
      miscompares++;
      $display("FAIL ferr_recover: no word captured, expected dout=%h", e.d);
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        miscompares++;
        $display("FAIL ferr_recover: got dout=%h v=%b fe=%b ov=%b, expected dout=%h v=%b fe=%b ov=%b",
                 o.d, o.v, o.fe, o.ov, e.d, e.v, e.fe, e.ov);
      end
    end
    do_read();
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    push_exp(8'h11, 1'b0);
    send_frame(8'h11, 1'b1, -1, C_FRAME);
    push_exp(8'h22, 1'b0);
    send_frame(8'h22, 1'b1, -1, C_FRAME);
    wait_obs(2);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_frame%0d: no word captured, expected dout=%h", k, e.d);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL b2b_frame%0d: got dout=%h v=%b fe=%b ov=%b, expected dout=%h v=%b fe=%b ov=%b",
                   k, o.d, o.v, o.fe, o.ov, e.d, e.v, e.fe, e.ov);
        end
      end
    end
    do_read();
    vectors++;
    if ({rx_valid, overrun} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_read_clear: got rx_valid=%b overrun=%b, expected 0 0", rx_valid, overrun);
    end
  endtask

  task automatic test_reset_abort();
    res_t o, e;
    int   d0 = done_cnt;
    send_frame(8'hC3, 1'b1, -1, 72);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx    = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    for (int t = 0; t < 160; t++) next_tick();
    @(negedge clk);
    vectors++;
    if (done_cnt !== d0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d pulses, expected 0", done_cnt - d0);
    end
    push_exp(8'h7E, 1'b0);
    send_frame(8'h7E, 1'b1, -1, C_FRAME);
    wait_obs(1);
    e = exp_q.pop_front();
    vectors++;
    if (obs_q.size() == 0) begin
      miscompares++;
      $display("FAIL abort_next_frame: no word captured, expected dout=%h", e.d);
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        miscompares++;
        $display("FAIL abort_next_frame: got dout=%h v=%b fe=%b ov=%b, expected dout=%h v=%b fe=%b ov=%b",
                 o.d, o.v, o.fe, o.ov, e.d, e.v, e.fe, e.ov);
      end
    end
    do_read();
  endtask

  task automatic test_sample_glitch();
    res_t o, e;
    logic [7:0] d_exp;
    int   gt;
`ifdef UART_RX_MAJORITY_VOTE_EN
    gt    = 54;
    d_exp = 8'hFF;
`else
    gt    = 55;
    d_exp = 8'hFB;
`endif
    push_exp(d_exp, 1'b0);
    send_frame(8'hFF, 1'b1, gt, C_FRAME);
    wait_obs(1);
    e = exp_q.pop_front();
    vectors++;
    if (obs_q.size() == 0) begin
      miscompares++;
      $display("FAIL sample_glitch: no word captured, expected dout=%h", e.d);
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        miscompares++;
        $display("FAIL sample_glitch: got dout=%h v=%b fe=%b ov=%b, expected dout=%h v=%b fe=%b ov=%b",
                 o.d, o.v, o.fe, o.ov, e.d, e.v, e.fe, e.ov);
      end
    end
    do_read();
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_start_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_abort();
    test_sample_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
